// File: rtl/world_map_arb_if.sv
// Signal bundle between the world map arbiter, the bot register block,
// the video scanner and the map memory.
interface world_map_arb_if;
    logic [7:0]  bot_x;
    logic [7:0]  bot_y;
    logic [1:0]  bot_val;
    logic        bot_busy;
    logic        vid_req;
    logic [6:0]  vid_x;
    logic [6:0]  vid_y;
    logic        vid_ack;
    logic [1:0]  vid_val;
    logic        vid_valid;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic [1:0]  mem_data;

    modport slave (
        input  bot_x, bot_y, vid_req, vid_x, vid_y, mem_data,
        output bot_val, bot_busy, vid_ack, vid_val, vid_valid, mem_rd, mem_addr
    );

    modport master (
        output bot_x, bot_y, vid_req, vid_x, vid_y, mem_data,
        input  bot_val, bot_busy, vid_ack, vid_val, vid_valid, mem_rd, mem_addr
    );
endinterface

// File: rtl/world_map_arb.sv
// Shares the single-port world map between BOT lookups (priority, bounded latency)
// and a req/ack video scanner, with a wait counter that forces video grants.
module world_map_arb #(
    parameter int         MEM_LAT      = 1,
    parameter int         VID_MAX_WAIT = 4,
    parameter logic [1:0] OOB_VAL      = 2'b11
) (
    input  logic           clk,
    input  logic           reset,
    world_map_arb_if.slave bus
);
    localparam int            WW       = (VID_MAX_WAIT < 1) ? 1 : $clog2(VID_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(VID_MAX_WAIT);
    localparam logic          OWN_BOT  = 1'b0;
    localparam logic          OWN_VID  = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic gen;
    } tag_t;

    logic [7:0]       sh_x, sh_y;
    logic             bot_pend, gen;
    logic [WW-1:0]    vid_wait;
    tag_t [MEM_LAT:0] tag_pipe, tag_nxt;
    tag_t             tag_out, push;
    logic             bot_chg, gen_nxt, bot_oob, vid_force, grant_bot, grant_vid;
    logic             bot_busy_c;
    logic             mem_rd_q, vid_ack_q, vid_valid_q;
    logic [13:0]      mem_addr_q;
    logic [1:0]       bot_val_q, vid_val_q;

    always_comb begin
        bot_chg   = (bus.bot_x != sh_x) || (bus.bot_y != sh_y);
        gen_nxt   = gen ^ bot_chg;
        bot_oob   = sh_x[7] | sh_y[7];
        vid_force = bus.vid_req && (vid_wait == WAIT_MAX);
        grant_bot = bot_pend && !vid_force;
        grant_vid = bus.vid_req && !grant_bot;
        tag_out   = tag_pipe[MEM_LAT];
    end

    // A newly accepted coordinate also kills every BOT tag still in flight, so a
    // 1-bit generation cannot alias across two quick coordinate changes.
    always_comb begin
        push = '0;
        if (grant_vid)
            push = '{valid: 1'b1, owner: OWN_VID, gen: gen};
        else if (grant_bot && !bot_oob)
            push = '{valid: 1'b1, owner: OWN_BOT, gen: gen};
        tag_nxt[0] = push;
        for (int i = 1; i <= MEM_LAT; i++)
            tag_nxt[i] = tag_pipe[i-1];
        if (bot_chg) begin
            for (int i = 0; i <= MEM_LAT; i++)
                if (tag_nxt[i].owner == OWN_BOT)
                    tag_nxt[i].valid = 1'b0;
        end
    end

    always_comb begin
        bot_busy_c = bot_pend;
        for (int i = 0; i <= MEM_LAT; i++)
            if (tag_pipe[i].valid && tag_pipe[i].owner == OWN_BOT)
                bot_busy_c = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_x        <= '0;
            sh_y        <= '0;
            gen         <= 1'b0;
            bot_pend    <= 1'b1;
            vid_wait    <= '0;
            tag_pipe    <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            bot_val_q   <= '0;
            vid_ack_q   <= 1'b0;
            vid_val_q   <= '0;
            vid_valid_q <= 1'b0;
        end else begin
            if (bot_chg) begin
                sh_x <= bus.bot_x;
                sh_y <= bus.bot_y;
            end
            gen      <= gen_nxt;
            bot_pend <= bot_chg || (bot_pend && !grant_bot);
            tag_pipe <= tag_nxt;

            if (grant_vid || !bus.vid_req)
                vid_wait <= '0;
            else if (vid_wait != WAIT_MAX)
                vid_wait <= vid_wait + 1'b1;

            vid_ack_q <= grant_vid;
            mem_rd_q  <= 1'b0;
            if (grant_vid) begin
                mem_rd_q   <= 1'b1;
                mem_addr_q <= {bus.vid_y, bus.vid_x};
            end else if (grant_bot && !bot_oob) begin
                mem_rd_q   <= 1'b1;
                mem_addr_q <= {sh_y[6:0], sh_x[6:0]};
            end

            // Compare against the post-edge generation so a coordinate accepted
            // on this same edge already suppresses the older result.
            vid_valid_q <= 1'b0;
            if (tag_out.valid) begin
                if (tag_out.owner == OWN_VID) begin
                    vid_val_q   <= bus.mem_data;
                    vid_valid_q <= 1'b1;
                end else if (tag_out.gen == gen_nxt) begin
                    bot_val_q <= bus.mem_data;
                end
            end
            if (grant_bot && bot_oob)
                bot_val_q <= OOB_VAL;
        end
    end

    assign bus.bot_val   = bot_val_q;
    assign bus.bot_busy  = bot_busy_c;
    assign bus.vid_ack   = vid_ack_q;
    assign bus.vid_val   = vid_val_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_world_map_arb.sv
// Directed and randomized bench for world_map_arb with a behavioural map
// memory, a video result scoreboard and BOT result expectations.
module tb_world_map_arb;
    localparam int         MEM_LAT      = 1;
    localparam int         VID_MAX_WAIT = 4;
    localparam logic [1:0] OOB_VAL      = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    world_map_arb_if bus();

    world_map_arb #(
        .MEM_LAT      (MEM_LAT),
        .VID_MAX_WAIT (VID_MAX_WAIT),
        .OOB_VAL      (OOB_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural map memory: address sampled at a clock edge, data MEM_LAT edges later.
    logic [1:0] mem [0:16383];
    logic [1:0] rdp [MEM_LAT];
    always @(posedge clk) begin
        rdp[0] <= mem[bus.mem_addr];
        for (int i = 1; i < MEM_LAT; i++)
            rdp[i] <= rdp[i-1];
    end
    assign bus.mem_data = rdp[MEM_LAT-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vdeny    = 0;
    logic [1:0] vq_val [$];
    int         vq_due [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int addr_of(input int x, input int y);
        return y * 128 + x;
    endfunction

    function automatic logic [1:0] bot_exp(input logic [7:0] x, input logic [7:0] y);
        if (x > 8'd127 || y > 8'd127)
            return OOB_VAL;
        return mem[addr_of(int'(x), int'(y))];
    endfunction

    // One clock: observe outputs just after the edge, then run the standing checks.
    task automatic tick();
        logic req_before;
        logic exp_v;
        req_before = bus.vid_req;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.vid_ack) begin
            chk("vid_ack_req", 32'(req_before), 32'd1);
            chk("vid_ack_rd", 32'(bus.mem_rd), 32'd1);
            chk("vid_ack_addr", 32'(bus.mem_addr), addr_of(int'(bus.vid_x), int'(bus.vid_y)));
            vq_val.push_back(mem[addr_of(int'(bus.vid_x), int'(bus.vid_y))]);
            vq_due.push_back(cyc + MEM_LAT + 1);
        end
        exp_v = (vq_due.size() > 0) && (vq_due[0] == cyc);
        chk("vid_valid", 32'(bus.vid_valid), 32'(exp_v));
        if (exp_v) begin
            chk("vid_val", 32'(bus.vid_val), 32'(vq_val[0]));
            void'(vq_val.pop_front());
            void'(vq_due.pop_front());
        end
        if (req_before) begin
            vdeny = bus.vid_ack ? 0 : vdeny + 1;
            chk("vid_starve", 32'(vdeny <= VID_MAX_WAIT), 32'd1);
        end else begin
            vdeny = 0;
        end
        if (reset && !bus.bot_busy)
            chk("bot_idle_val", 32'(bus.bot_val), 32'(bot_exp(bus.bot_x, bus.bot_y)));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bot_val"}, 32'(bus.bot_val), 32'd0);
        chk({tag, "_bot_busy"}, 32'(bus.bot_busy), 32'd1);
        chk({tag, "_vid_ack"}, 32'(bus.vid_ack), 32'd0);
        chk({tag, "_vid_val"}, 32'(bus.vid_val), 32'd0);
        chk({tag, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
        chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    endtask

    initial begin
        int  n;
        logic got;
        reset       = 1'b0;
        bus.bot_x   = '0;
        bus.bot_y   = '0;
        bus.vid_req = 1'b0;
        bus.vid_x   = '0;
        bus.vid_y   = '0;
        for (int i = 0; i < 16384; i++)
            mem[i] = 2'($urandom);
        mem[0]               = 2'b10;
        mem[addr_of(5, 3)]   = 2'b01;

        // Reset state, then the automatic (0,0) fetch.
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset = 1'b1;
        tick();
        chk("rel_mem_rd", 32'(bus.mem_rd), 32'd1);
        chk("rel_mem_addr", 32'(bus.mem_addr), 32'd0);
        tick();
        chk("rel_busy_mid", 32'(bus.bot_busy), 32'd1);
        tick();
        chk("rel_bot_val", 32'(bus.bot_val), 32'd2);
        chk("rel_busy_done", 32'(bus.bot_busy), 32'd0);

        // In-range BOT lookup latency.
        bus.bot_x = 8'd5;
        bus.bot_y = 8'd3;
        tick();
        chk("b2_busy", 32'(bus.bot_busy), 32'd1);
        chk("b2_no_rd", 32'(bus.mem_rd), 32'd0);
        tick();
        chk("b2_rd", 32'(bus.mem_rd), 32'd1);
        chk("b2_addr", 32'(bus.mem_addr), addr_of(5, 3));
        tick();
        chk("b2_val_early", 32'(bus.bot_val), 32'd2);
        tick();
        chk("b2_val", 32'(bus.bot_val), 32'(bot_exp(8'd5, 8'd3)));
        chk("b2_busy_done", 32'(bus.bot_busy), 32'd0);

        // Out-of-range BOT lookup: no memory access, 2-cycle result.
        bus.bot_x = 8'h80;
        tick();
        chk("oob_no_rd0", 32'(bus.mem_rd), 32'd0);
        tick();
        chk("oob_no_rd1", 32'(bus.mem_rd), 32'd0);
        chk("oob_val", 32'(bus.bot_val), 32'(OOB_VAL));
        chk("oob_busy", 32'(bus.bot_busy), 32'd0);

        // Video starved by a constantly changing BOT coordinate gets a forced grant.
        bus.bot_x = 8'h10;
        tick();
        bus.vid_req = 1'b1;
        bus.vid_x   = 7'd10;
        bus.vid_y   = 7'd20;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            bus.bot_x = bus.bot_x + 8'd1;
            tick();
            n++;
            got = bus.vid_ack;
        end
        chk("force_edges", n, VID_MAX_WAIT + 1);
        chk("force_addr", 32'(bus.mem_addr), addr_of(10, 20));
        bus.vid_req = 1'b0;
        tick();
        chk("force_valid_lag1", 32'(bus.vid_valid), 32'd0);
        tick();
        chk("force_valid_lag2", 32'(bus.vid_valid), 32'd1);
        chk("force_val", 32'(bus.vid_val), 32'(mem[addr_of(10, 20)]));
        repeat (4) tick();
        chk("force_bot_settle", 32'(bus.bot_val), 32'(bot_exp(bus.bot_x, bus.bot_y)));

        // Coordinate change right after a grant: the older cell must never show.
        mem[addr_of(7, 1)] = 2'b01;
        mem[addr_of(9, 1)] = 2'b11;
        bus.bot_x = 8'h80;
        bus.bot_y = 8'd1;
        repeat (4) tick();
        chk("stale_pre", 32'(bus.bot_val), 32'(OOB_VAL));
        bus.bot_x = 8'd7;
        tick();
        tick();
        chk("stale_grant7", 32'(bus.mem_addr), addr_of(7, 1));
        bus.bot_x = 8'd9;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stale_never7", 32'(bus.bot_val), 32'd3);
            if (i == 1)
                chk("stale_grant9", 32'(bus.mem_addr), addr_of(9, 1));
        end
        chk("stale_busy", 32'(bus.bot_busy), 32'd0);

        // Back-to-back video grants with stepping addresses.
        bus.vid_req = 1'b1;
        bus.vid_x   = 7'd0;
        bus.vid_y   = 7'd5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("b2b_ack", 32'(bus.vid_ack), 32'd1);
            bus.vid_x = bus.vid_x + 7'd3;
        end
        bus.vid_req = 1'b0;
        repeat (3) tick();
        chk("b2b_drain", vq_due.size(), 0);

        // Randomized mix of BOT coordinate changes and video traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                bus.bot_x = ($urandom_range(7) == 0) ? (8'($urandom) | 8'h80) : 8'($urandom_range(127));
                bus.bot_y = ($urandom_range(15) == 0) ? 8'h80 : 8'($urandom_range(127));
            end
            if (!bus.vid_req || bus.vid_ack) begin
                bus.vid_req = 1'($urandom_range(1));
                bus.vid_x   = 7'($urandom);
                bus.vid_y   = 7'($urandom);
            end
            tick();
        end
        bus.vid_req = 1'b0;
        repeat (MEM_LAT + 6) tick();
        chk("rand_bot_busy", 32'(bus.bot_busy), 32'd0);
        chk("rand_bot_val", 32'(bus.bot_val), 32'(bot_exp(bus.bot_x, bus.bot_y)));
        chk("rand_vid_drain", vq_due.size(), 0);

        // Reset with a video result in flight: it must be dropped.
        bus.vid_req = 1'b1;
        bus.vid_x   = 7'd3;
        bus.vid_y   = 7'd4;
        bus.bot_x   = 8'd40;
        tick();
        chk("mid_ack", 32'(bus.vid_ack), 32'd1);
        bus.vid_req = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        vq_val.delete();
        vq_due.delete();
        bus.bot_x = 8'd0;
        bus.bot_y = 8'd0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("mid_rel_rd", 32'(bus.mem_rd), 32'd1);
        chk("mid_rel_addr", 32'(bus.mem_addr), 32'd0);
        tick();
        tick();
        chk("mid_rel_val", 32'(bus.bot_val), 32'(mem[0]));
        chk("mid_rel_busy", 32'(bus.bot_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
